// File: rtl/signal_stats_pkg.sv
// Shared constants, trip-point helpers and the result record for signal_stats.
package signal_stats_pkg;
  localparam int DEF_DW      = 8;
  localparam int DEF_WIN_LEN = 50_000_000;
  localparam int DEF_HYST    = 4;
  localparam int DEF_CNT_W   = 32;

  localparam int ST_DW    = DEF_DW;
  localparam int ST_CNT_W = DEF_CNT_W;

  typedef struct packed {
    logic [ST_DW-1:0]    vmax;
    logic [ST_DW-1:0]    vmin;
    logic [ST_DW-1:0]    vpp;
    logic [ST_DW-1:0]    vmid;
    logic [ST_CNT_W-1:0] edge_cnt;
    logic                no_data;
    logic                flat;
  } stats_t;

  function automatic int unsigned sat_add(int unsigned a, int unsigned b, int unsigned lim);
    return (a + b > lim) ? lim : a + b;
  endfunction

  function automatic int unsigned sat_sub(int unsigned a, int unsigned b);
    return (a > b) ? a - b : 0;
  endfunction
endpackage

// File: rtl/signal_stats_schmitt_edge_counter.sv
// Hysteresis comparator around a moving threshold plus a saturating rising-edge counter.
module schmitt_edge_counter
  import signal_stats_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int HYST  = DEF_HYST,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [DW-1:0]    din,
  input  logic [DW-1:0]    thr,
  input  logic             clr,
  output logic             hi,
  output logic [CNT_W-1:0] ecnt,
  output logic             rise
);
  localparam int unsigned DMAX = (1 << DW) - 1;

  logic [DW-1:0] upper, lower;
  logic          fall;

  always_comb begin
    upper = DW'(sat_add(32'(thr), 32'(HYST), DMAX));
    lower = DW'(sat_sub(32'(thr), 32'(HYST)));
    rise  = din_valid && !hi && (din >= upper);
    fall  = din_valid &&  hi && (din <= lower);
  end

  // clr wins over a same-cycle increment; the parent folds that increment in itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi   <= 1'b0;
      ecnt <= '0;
    end else begin
      if (rise)      hi <= 1'b1;
      else if (fall) hi <= 1'b0;
      if (clr)                     ecnt <= '0;
      else if (rise && ecnt != '1) ecnt <= ecnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/signal_stats.sv
// Windowed max/min/p-p/mid and hysteresis-qualified crossing count; threshold follows last window's midpoint.
module signal_stats
  import signal_stats_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int HYST    = DEF_HYST,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [DW-1:0]    din,
  output logic             out_valid,
  output logic [DW-1:0]    vmax,
  output logic [DW-1:0]    vmin,
  output logic [DW-1:0]    vpp,
  output logic [DW-1:0]    vmid,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             no_data,
  output logic             flat
);
  // Window counter is wide enough for WIN_LEN even when the crossing counter is narrow.
  localparam int WCW = (CNT_W > $clog2(WIN_LEN)) ? CNT_W : $clog2(WIN_LEN);
  localparam logic [WCW-1:0] LAST  = WCW'(WIN_LEN - 1);
  localparam logic [DW:0]    TWO_H = (DW+1)'(2 * HYST);

  logic [WCW-1:0]   wcnt;
  logic [DW-1:0]    rmax, rmin, thr;
  logic             seen;
  logic             hi_unused, rise;
  logic [CNT_W-1:0] ecnt, ecnt_fin;
  logic [DW-1:0]    nmax, nmin, npp, nmid;
  logic             nseen, close, nflat;

  schmitt_edge_counter #(.DW(DW), .HYST(HYST), .CNT_W(CNT_W)) u_sec (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .thr(thr), .clr(close),
    .hi(hi_unused), .ecnt(ecnt), .rise(rise)
  );

  always_comb begin
    close    = (wcnt == LAST);
    nmax     = (din_valid && din > rmax) ? din : rmax;
    nmin     = (din_valid && din < rmin) ? din : rmin;
    nseen    = seen | din_valid;
    npp      = nmax - nmin;
    nmid     = DW'(({1'b0, nmax} + {1'b0, nmin}) >> 1);
    nflat    = ({1'b0, npp} < TWO_H);
    ecnt_fin = (rise && ecnt != '1) ? ecnt + CNT_W'(1) : ecnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      rmax      <= '0;
      rmin      <= '1;
      seen      <= 1'b0;
      thr       <= {1'b1, {(DW-1){1'b0}}};
      out_valid <= 1'b0;
      vmax      <= '0;
      vmin      <= '0;
      vpp       <= '0;
      vmid      <= '0;
      edge_cnt  <= '0;
      no_data   <= 1'b0;
      flat      <= 1'b0;
    end else begin
      out_valid <= close;
      if (close) begin
        wcnt <= '0;
        rmax <= '0;
        rmin <= '1;
        seen <= 1'b0;
        if (nseen) begin
          vmax     <= nmax;
          vmin     <= nmin;
          vpp      <= npp;
          vmid     <= nmid;
          edge_cnt <= ecnt_fin;
          no_data  <= 1'b0;
          flat     <= nflat;
          if (!nflat) thr <= nmid;
        end else begin
          vmax     <= '0;
          vmin     <= '0;
          vpp      <= '0;
          vmid     <= '0;
          edge_cnt <= '0;
          no_data  <= 1'b1;
          flat     <= 1'b1;
        end
      end else begin
        wcnt <= wcnt + WCW'(1);
        rmax <= nmax;
        rmin <= nmin;
        seen <= nseen;
      end
    end
  end
endmodule

// File: tb/tb_signal_stats.sv
// Directed-window bench for signal_stats with a window-level reference model checked every cycle.
module tb_signal_stats;
  import signal_stats_pkg::*;

  localparam int WIN  = 1000;
  localparam int HYST = 4;
  localparam int WIN2 = 40;

  localparam int K_NONE = 0, K_C200 = 1, K_SQ = 2, K_TRI = 3, K_DITH = 4,
                 K_EDGE = 5, K_S7 = 6, K_C60 = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic [7:0]  din;
  logic        out_valid;
  logic [7:0]  vmax, vmin, vpp, vmid;
  logic [31:0] edge_cnt;
  logic        no_data, flat;

  logic        din_valid2 = 1'b1;
  logic [7:0]  din2 = 8'd0;
  logic        out_valid2;
  logic [7:0]  vmax2, vmin2, vpp2, vmid2;
  logic [2:0]  edge_cnt2;
  logic        no_data2, flat2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signal_stats #(.DW(8), .WIN_LEN(WIN), .HYST(HYST), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .out_valid(out_valid),
    .vmax(vmax), .vmin(vmin), .vpp(vpp), .vmid(vmid), .edge_cnt(edge_cnt),
    .no_data(no_data), .flat(flat)
  );

  // Narrow crossing counter so saturation is reachable in a short window.
  signal_stats #(.DW(8), .WIN_LEN(WIN2), .HYST(HYST), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .din_valid(din_valid2), .din(din2), .out_valid(out_valid2),
    .vmax(vmax2), .vmin(vmin2), .vpp(vpp2), .vmid(vmid2), .edge_cnt(edge_cnt2),
    .no_data(no_data2), .flat(flat2)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: collects each window's valid samples and derives the statistics from them.
  int     q[$];
  int     wpos, m_thr, m_cnt;
  bit     m_hi, m_ov, started = 1'b0;
  stats_t m_e;

  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      m_ov = 1'b0; m_e = '0; m_thr = 128; m_hi = 1'b0;
      q.delete(); wpos = 0; m_cnt = 0;
    end else if (started) begin
      int up, lo, s;
      m_ov = 1'b0;
      if (din_valid) begin
        s  = int'(din);
        q.push_back(s);
        up = (m_thr + HYST > 255) ? 255 : m_thr + HYST;
        lo = (m_thr - HYST < 0) ? 0 : m_thr - HYST;
        if (!m_hi && s >= up) begin
          m_hi = 1'b1;
          m_cnt++;
        end else if (m_hi && s <= lo) begin
          m_hi = 1'b0;
        end
      end
      wpos++;
      if (wpos == WIN) begin
        m_ov = 1'b1;
        m_e  = '0;
        if (q.size() == 0) begin
          m_e.no_data = 1'b1;
          m_e.flat    = 1'b1;
        end else begin
          int mx, mn;
          mx = 0; mn = 255;
          foreach (q[k]) begin
            if (q[k] > mx) mx = q[k];
            if (q[k] < mn) mn = q[k];
          end
          m_e.vmax     = 8'(mx);
          m_e.vmin     = 8'(mn);
          m_e.vpp      = 8'(mx - mn);
          m_e.vmid     = 8'((mx + mn) / 2);
          m_e.edge_cnt = 32'(m_cnt);
          m_e.flat     = (mx - mn) < 2 * HYST;
          if (!m_e.flat) m_thr = (mx + mn) / 2;
        end
        q.delete(); wpos = 0; m_cnt = 0;
      end
    end
    #1;
    if (started) begin
      chk("out_valid", out_valid, m_ov);
      chk("vmax", vmax, m_e.vmax);
      chk("vmin", vmin, m_e.vmin);
      chk("vpp", vpp, m_e.vpp);
      chk("vmid", vmid, m_e.vmid);
      chk("edge_cnt", edge_cnt, m_e.edge_cnt);
      chk("no_data", no_data, m_e.no_data);
      chk("flat", flat, m_e.flat);
    end
  end

  always @(negedge clk) din2 = (din2 == 8'd255) ? 8'd0 : 8'd255;

  initial begin
    @(negedge rst);
    repeat (WIN2) @(negedge clk);
    chk("sat_out_valid", out_valid2, 1);
    chk("sat_edge_cnt", edge_cnt2, 7);
    chk("sat_vmax", vmax2, 255);
    chk("sat_vmin", vmin2, 0);
  end

  task automatic drive(input int kind, input int i);
    int t;
    din_valid = 1'b1;
    case (kind)
      K_NONE: begin din_valid = 1'b0; din = 8'd0; end
      K_C200: din = 8'd200;
      K_SQ:   din = ((i % 100) < 50) ? 8'd50 : 8'd250;
      K_TRI:  begin t = i % 32; din = (t <= 16) ? 8'(120 + t) : 8'(152 - t); end
      K_DITH: begin t = i % 8;  din = (t <= 4)  ? 8'(126 + t) : 8'(134 - t); end
      K_EDGE: begin din_valid = (i == 500 || i == 999); din = (i == 999) ? 8'd255 : 8'd100; end
      K_S7:   begin din_valid = (i == 0); din = 8'd7; end
      default: din = 8'd60;
    endcase
  endtask

  task automatic run_window(input int kind);
    for (int i = 0; i < WIN; i++) begin
      drive(kind, i);
      @(negedge clk);
    end
  endtask

  task automatic lit(input string n, input logic [7:0] mx, input logic [7:0] mn, input logic [7:0] pp,
                     input logic [7:0] md, input logic [31:0] ec, input logic fl, input logic [7:0] th);
    chk({n, "_ov"}, out_valid, 1);
    chk({n, "_vmax"}, vmax, mx);
    chk({n, "_vmin"}, vmin, mn);
    chk({n, "_vpp"}, vpp, pp);
    chk({n, "_vmid"}, vmid, md);
    chk({n, "_edge"}, edge_cnt, ec);
    chk({n, "_flat"}, flat, fl);
    chk({n, "_thr"}, dut.thr, th);
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_vmax", vmax, 0);
    chk("rst_vmin", vmin, 0);
    chk("rst_edge", edge_cnt, 0);
    chk("rst_no_data", no_data, 0);
    chk("rst_flat", flat, 0);
    chk("rst_thr", dut.thr, 128);
    rst = 1'b0;

    run_window(K_NONE);
    lit("empty", 0, 0, 0, 0, 0, 1, 128);
    chk("empty_no_data", no_data, 1);

    run_window(K_C200);
    run_window(K_C200);
    lit("const", 200, 200, 0, 200, 0, 1, 128);

    run_window(K_SQ);
    lit("sq1", 250, 50, 200, 150, 10, 0, 150);
    run_window(K_SQ);
    lit("sq2", 250, 50, 200, 150, 10, 0, 150);

    run_window(K_TRI);
    lit("tri0", 136, 120, 16, 128, 0, 0, 128);
    run_window(K_TRI);
    lit("tri", 136, 120, 16, 128, 31, 0, 128);
    run_window(K_DITH);
    lit("dither", 130, 126, 4, 128, 0, 1, 128);

    run_window(K_EDGE);
    lit("wrap255", 255, 100, 155, 177, 1, 0, 177);
    run_window(K_S7);
    lit("single7", 7, 7, 0, 7, 0, 1, 177);

    for (int i = 0; i < 500; i++) begin
      drive(K_C60, i);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ov", out_valid, 0);
    rst = 1'b0;
    run_window(K_C60);
    lit("midrst", 60, 60, 0, 60, 0, 1, 128);

    din_valid = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
